// File: rtl/whack_pkg.sv
// Shared types and helpers for the whack-a-mole button judging path.
// Provides the judge FSM state type, the index-width helper and a
// lowest-set-bit encoder used to pick one hole out of several presses.
package whack_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        LOCKOUT = 2'd2
    } judge_state_t;

    // Width of a hole index; a single-hole build still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Index of the lowest set bit of v (0 when v is empty).
    function automatic logic [3:0] lowest_set(input logic [15:0] v);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) begin
                idx = 4'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/hit_judge_btn_debounce.sv
// Per-button front end: two-flop synchronizer, stability-counter debouncer
// and rising-edge detector. press_evt is a one-cycle pulse on each debounced
// press; releases produce nothing.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic press_evt
);

    // Counts up to DEBOUNCE_CYCLES-1; the flip happens on the next differing cycle.
    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          level_q, level_d;
    logic          level_d1_q, level_d1_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Next-state: shift synchronizer, count differing cycles, flip level once stable.
    always_comb begin
        sync1_d    = btn_raw;
        sync2_d    = sync1_q;
        level_d1_d = level_q;
        level_d    = level_q;
        cnt_d      = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                level_d = sync2_q;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else begin
            cnt_d = '0;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            level_q    <= 1'b0;
            level_d1_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            level_q    <= level_d;
            level_d1_q <= level_d1_d;
            cnt_q      <= cnt_d;
        end
    end

    assign press_evt = level_q & ~level_d1_q;

endmodule

// File: rtl/hit_judge.sv
// Turns raw player buttons into registered single-cycle hit/miss events.
// Each button is debounced by its own btn_debounce instance; presses are
// judged against the mole-up mask, the lowest-index hit wins, and a lockout
// window after each hit discards further presses.
// Build option: define HIT_JUDGE_MISS_EN to generate miss_pulse on presses
// into empty holes; otherwise miss_pulse is tied low and the logic is absent.
module hit_judge
    import whack_pkg::*;
#(
    parameter int N_HOLES         = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int LOCKOUT_CYCLES  = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            enable,
    input  logic [N_HOLES-1:0]              btn_raw,
    input  logic [N_HOLES-1:0]              mole_mask,
    output logic                            hit_pulse,
    output logic                            miss_pulse,
    output logic [idx_width(N_HOLES)-1:0]   hit_idx,
    output logic [N_HOLES-1:0]              mole_clear
);

    localparam int IW = idx_width(N_HOLES);
    localparam int LW = $clog2(LOCKOUT_CYCLES + 1);

    logic [N_HOLES-1:0] press_evt;
    logic [N_HOLES-1:0] hits;

    judge_state_t       state_q, state_d;
    logic [LW-1:0]      lock_q, lock_d;
    logic               hit_pulse_q, hit_pulse_d;
    logic [IW-1:0]      hit_idx_q, hit_idx_d;
    logic [N_HOLES-1:0] mole_clear_q, mole_clear_d;
`ifdef HIT_JUDGE_MISS_EN
    logic               miss_pulse_q, miss_pulse_d;
`endif

    for (genvar g = 0; g < N_HOLES; g++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_btn_debounce (
            .clk       (clk),
            .rst       (rst),
            .btn_raw   (btn_raw[g]),
            .press_evt (press_evt[g])
        );
    end

    // The mask is sampled in the same cycle as the press, never latched.
    assign hits = press_evt & mole_mask;

    // Judge FSM: arm, pick the lowest hit hole, then hold off for the lockout window.
    always_comb begin
        state_d      = state_q;
        lock_d       = lock_q;
        hit_pulse_d  = 1'b0;
        hit_idx_d    = hit_idx_q;
        mole_clear_d = '0;
`ifdef HIT_JUDGE_MISS_EN
        miss_pulse_d = 1'b0;
`endif
        if (!enable) begin
            state_d = IDLE;
            lock_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = ARMED;
                end
                ARMED: begin
                    if (hits != '0) begin
                        hit_pulse_d             = 1'b1;
                        hit_idx_d               = IW'(lowest_set(16'(hits)));
                        mole_clear_d[hit_idx_d] = 1'b1;
                        state_d                 = LOCKOUT;
                        lock_d                  = LW'(LOCKOUT_CYCLES);
                    end else begin
`ifdef HIT_JUDGE_MISS_EN
                        miss_pulse_d = (press_evt != '0);
`endif
                        state_d = ARMED;
                    end
                end
                LOCKOUT: begin
                    // Presses arriving here are simply dropped.
                    if (lock_q == '0) begin
                        state_d = ARMED;
                    end else begin
                        lock_d = lock_q - LW'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    lock_d  = '0;
                end
            endcase
        end
    end

    // FSM and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            lock_q       <= '0;
            hit_pulse_q  <= 1'b0;
            hit_idx_q    <= '0;
            mole_clear_q <= '0;
        end else begin
            state_q      <= state_d;
            lock_q       <= lock_d;
            hit_pulse_q  <= hit_pulse_d;
            hit_idx_q    <= hit_idx_d;
            mole_clear_q <= mole_clear_d;
        end
    end

`ifdef HIT_JUDGE_MISS_EN
    // Miss pulse register, present only in the miss-reporting build.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            miss_pulse_q <= 1'b0;
        end else begin
            miss_pulse_q <= miss_pulse_d;
        end
    end

    assign miss_pulse = miss_pulse_q;
`else
    assign miss_pulse = 1'b0;
`endif

    assign hit_pulse  = hit_pulse_q;
    assign hit_idx    = hit_idx_q;
    assign mole_clear = mole_clear_q;

endmodule
